// File: rtl/mux16_rr_arbiter_if.sv
// Handshake/bus bundle between the 16-channel round-robin arbiter and its environment.
// master = arbiter side (drives select/grant/valid), slave = requesters plus downstream consumer.
interface mux16_rr_arbiter_if;
    localparam int unsigned N_CH  = 16;
    localparam int unsigned SEL_W = 4;

    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  en;
    logic             out_ready;
    logic [SEL_W-1:0] sel;
    logic [N_CH-1:0]  grant;
    logic             out_valid;

    modport master (
        input  req,
        input  en,
        input  out_ready,
        output sel,
        output grant,
        output out_valid
    );

    modport slave (
        output req,
        output en,
        output out_ready,
        input  sel,
        input  grant,
        input  out_valid
    );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving a shared 16:1 mux select with per-grant burst limiting.
// Optional macro MUX16_ARB_LOCK_EN adds a 'lock' input that suppresses the burst-limit release.
module mux16_rr_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef MUX16_ARB_LOCK_EN
    input  logic                      lock,
`endif
    mux16_rr_arbiter_if.master        bus
);
    localparam int unsigned N_CH  = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [N_CH-1:0]  grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic [N_CH-1:0]  elig_c;
    logic [SEL_W-1:0] start_c;
    logic [SEL_W-1:0] win_c;
    logic             win_vld_c;
    logic             fire_c;
    logic             burst_end_c;
    logic             lock_hold_c;
    logic             release_c;

    assign elig_c = bus.req & bus.en;

    // While granted the search starts just past the holder so it gets lowest priority on re-search.
    assign start_c = (state_q == ST_GRANT) ? sel_q + SEL_W'(1) : last_q + SEL_W'(1);

    // Rotating priority search; descending loop so the smallest offset from start_c wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        idx       = '0;
        win_c     = '0;
        win_vld_c = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = start_c + SEL_W'(k);
            if (elig_c[idx]) begin
                win_c     = idx;
                win_vld_c = 1'b1;
            end
        end
    end

`ifdef MUX16_ARB_LOCK_EN
    assign lock_hold_c = lock;
`else
    assign lock_hold_c = 1'b0;
`endif

    assign fire_c      = valid_q & bus.out_ready;
    assign burst_end_c = (beat_q == CNT_W'(MAX_BURST - 1));
    assign release_c   = !bus.req[sel_q] || !bus.en[sel_q]
                       || (fire_c && burst_end_c && !lock_hold_c);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        valid_d = valid_q;
        beat_d  = beat_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (win_vld_c) begin
                    state_d = ST_GRANT;
                    sel_d   = win_c;
                    grant_d = N_CH'(1) << win_c;
                    valid_d = 1'b1;
                    beat_d  = '0;
                end
            end

            ST_GRANT: begin
                if (release_c) begin
                    last_d = sel_q;
                    beat_d = '0;
                    if (win_vld_c) begin
                        state_d = ST_GRANT;
                        sel_d   = win_c;
                        grant_d = N_CH'(1) << win_c;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else if (fire_c && !burst_end_c) begin
                    // A locked grant at the limit keeps the counter saturated here.
                    beat_d = beat_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(N_CH - 1);
            grant_q <= '0;
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: a grant-level reference model checked every cycle plus
// hand-computed pinned expectations for the directed scenarios.
module tb_mux16_rr_arbiter;
    localparam int MAX_BURST = 4;

    logic clk;
    logic rst;
`ifdef MUX16_ARB_LOCK_EN
    logic lock;
`endif

    mux16_rr_arbiter_if bus ();

    mux16_rr_arbiter #(
        .MAX_BURST(MAX_BURST),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
`ifdef MUX16_ARB_LOCK_EN
        .lock(lock),
`endif
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: current holder (-1 = idle), last holder, beats transferred this grant.
    int          m_cur   = -1;
    int          m_last  = 15;
    int          m_beats = 0;
    logic [3:0]  m_sel   = 4'd0;
    logic [15:0] m_grant = 16'h0;
    logic        m_valid = 1'b0;

    function automatic int pick(input logic [15:0] e, input int start);
        for (int k = 0; k < 16; k++) begin
            if (e[(start + k) % 16]) return (start + k) % 16;
        end
        return -1;
    endfunction

    always begin
        logic [15:0] elig;
        logic        locked;
        logic        done;
        int          w;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cur   = -1;
            m_last  = 15;
            m_beats = 0;
            m_sel   = 4'd0;
        end else begin
            elig   = bus.req & bus.en;
            locked = 1'b0;
`ifdef MUX16_ARB_LOCK_EN
            locked = lock;
`endif
            if (m_cur < 0) begin
                w = pick(elig, (m_last + 1) % 16);
                if (w >= 0) begin
                    m_cur   = w;
                    m_sel   = 4'(w);
                    m_beats = 0;
                end
            end else begin
                if (bus.out_ready) m_beats++;
                done = bus.out_ready && (m_beats >= MAX_BURST) && !locked;
                if (!bus.req[m_cur] || !bus.en[m_cur] || done) begin
                    m_last  = m_cur;
                    w       = pick(elig, (m_cur + 1) % 16);
                    m_beats = 0;
                    m_cur   = w;
                    if (w >= 0) m_sel = 4'(w);
                end
            end
        end
        m_grant = (m_cur < 0) ? 16'h0 : (16'h1 << m_cur);
        m_valid = (m_cur >= 0);
    end

    // Pinned literal expectations, written only by the stimulus process.
    logic        pin_en;
    logic [15:0] pin_grant;
    logic [3:0]  pin_sel;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Single compare process: model every cycle, pinned values when armed.
    always begin
        @(posedge clk or posedge rst);
        #1;
        chk("model_grant", bus.grant, m_grant);
        chk("model_valid", 16'(bus.out_valid), 16'(m_valid));
        chk("model_sel", 16'(bus.sel), 16'(m_sel));
        if (pin_en) begin
            chk("pin_grant", bus.grant, pin_grant);
            chk("pin_valid", 16'(bus.out_valid), 16'(pin_grant != 16'h0));
            chk("pin_sel", 16'(bus.sel), 16'(pin_sel));
        end
    end

    task automatic cyc(input logic [15:0] g, input logic [3:0] s);
        pin_en    = 1'b1;
        pin_grant = g;
        pin_sel   = s;
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        pin_en    = 1'b1;
        pin_grant = 16'h0;
        pin_sel   = 4'd0;
        rst       = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int order [5];
        order = '{0, 5, 10, 15, 0};
        pin_en        = 1'b1;
        pin_grant     = 16'h0;
        pin_sel       = 4'd0;
        bus.req       = 16'h0;
        bus.en        = 16'h0;
        bus.out_ready = 1'b0;
`ifdef MUX16_ARB_LOCK_EN
        lock          = 1'b0;
`endif
        rst           = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Lone requester: grant next edge, re-granted after each burst without a bubble.
        bus.req = 16'h0001; bus.en = 16'hFFFF; bus.out_ready = 1'b1;
        rst = 1'b0;
        repeat (9) cyc(16'h0001, 4'd0);

        // Four requesters rotate 0,5,10,15,0 with exactly MAX_BURST cycles each.
        rst_pulse();
        bus.req = 16'h8421; bus.en = 16'hFFFF; bus.out_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++)
            repeat (4) cyc(16'h1 << order[i], 4'(order[i]));

        // Drop req[5] after two fires; ch0 then gets a fresh full burst.
        rst_pulse();
        bus.req = 16'h0021; bus.en = 16'hFFFF; bus.out_ready = 1'b1;
        rst = 1'b0;
        repeat (4) cyc(16'h0001, 4'd0);
        repeat (3) cyc(16'h0020, 4'd5);
        bus.req = 16'h0001;
        cyc(16'h0001, 4'd0);
        bus.req = 16'h0021;
        repeat (3) cyc(16'h0001, 4'd0);
        cyc(16'h0020, 4'd5);

        // Enable masking: ch9 never eligible; clearing en[8] idles with sel held.
        rst_pulse();
        bus.req = 16'h0300; bus.en = 16'h0100; bus.out_ready = 1'b1;
        rst = 1'b0;
        repeat (3) cyc(16'h0100, 4'd8);
        bus.en = 16'h0000;
        repeat (6) cyc(16'h0000, 4'd8);

        // Backpressure holds ch3 without counting beats; then a full burst moves to ch4.
        rst_pulse();
        bus.req = 16'h0018; bus.en = 16'hFFFF; bus.out_ready = 1'b0;
        rst = 1'b0;
        repeat (11) cyc(16'h0008, 4'd3);
        bus.out_ready = 1'b1;
        repeat (3) cyc(16'h0008, 4'd3);
        repeat (2) cyc(16'h0010, 4'd4);
        // Asynchronous reset mid-burst clears outputs without waiting for a clock edge.
        pin_grant = 16'h0;
        pin_sel   = 4'd0;
        #2 rst = 1'b1;
        @(negedge clk);

        // Max-burst boundary: a non-holder waiting shows the burst limit is exact.
        rst_pulse();
        bus.req = 16'h0003; bus.en = 16'hFFFF; bus.out_ready = 1'b1;
        rst = 1'b0;
        repeat (4) cyc(16'h0001, 4'd0);
        repeat (4) cyc(16'h0002, 4'd1);
        cyc(16'h0001, 4'd0);

`ifdef MUX16_ARB_LOCK_EN
        // Lock keeps ch0 for 20 fires; dropping it releases on the next fire.
        rst_pulse();
        lock = 1'b1;
        bus.req = 16'h0003; bus.en = 16'hFFFF; bus.out_ready = 1'b1;
        rst = 1'b0;
        repeat (21) cyc(16'h0001, 4'd0);
        lock = 1'b0;
        cyc(16'h0002, 4'd1);
`endif

        pin_en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
Round-robin arbiter that shares one 16:1 single-bit mux among 16 requesters. It drives the mux 4-bit select and issues a one-hot grant. It presents a valid/ready handshake to the downstream consumer of the mux output. It limits each grant to a burst of transfers so no requester starves.

Parameters:
MAX_BURST, 4, maximum transfers (valid&&ready beats) per grant; legal range 1..255.
CNT_W, 8, width of the internal beat counter; must hold MAX_BURST-1.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  16  per-channel request; req[i] high = channel i has data on mux input i
en  input  16  per-channel enable mask; channel eligible iff req[i] && en[i]
out_ready  input  1  downstream accepts the current mux output this cycle
sel  output  4  mux select; index of the granted channel
grant  output  16  one-hot grant; all-zero when idle
out_valid  output  1  mux output valid to downstream

Behaviour:
- Async reset, any time including mid-burst: sel=0, grant=0, out_valid=0, state=IDLE, beat_cnt=0, last pointer=15 so the first search starts at channel 0. All outputs registered.
- Eligible vector: elig = req & en.
- Search order: rotating from (last+1) mod 16 upward with wrap-around. The first eligible index wins.
- IDLE:
  - outputs grant=0, out_valid=0, sel holds its last value.
  - If elig!=0, go to GRANT. sel/grant take the winner at the next edge, so latency from req to grant is 1 cycle.
- GRANT:
  - outputs sel=w, grant=1<<w, out_valid=1.
  - fire = out_valid && out_ready; each fire increments beat_cnt.
- Release in GRANT, evaluated every cycle. Release when any of:
  - req[w]==0;
  - en[w]==0;
  - fire && beat_cnt==MAX_BURST-1.
- On release:
  - last=w, beat_cnt=0.
  - Re-search from (w+1) mod 16 over elig. The current channel has lowest priority but may re-win if it is still eligible and nothing else is.
  - If a winner exists, go straight to GRANT with the new sel/grant at the next edge (no idle bubble). Otherwise go to IDLE.
- Simultaneous fire and req[w] drop: the beat counts as transferred, and release proceeds.
- With out_ready=0: grant holds indefinitely while req[w]&&en[w]. beat_cnt does not advance.
- MAX_BURST=1: the grant moves after every fire.
- Changes to req/en of non-granted channels never disturb the current grant.
- grant is always one-hot or zero. out_valid==|grant. sel==index of grant when grant!=0.

Optional Feature:
MUX16_ARB_LOCK_EN
- Defined:
  - Adds input port lock (1 bit).
  - While in GRANT with lock=1, the MAX_BURST release condition is suppressed and beat_cnt saturates at MAX_BURST-1.
  - req[w]/en[w] deassertion still releases.
  - lock is ignored in IDLE.
  - When lock falls, release occurs on the next fire if beat_cnt==MAX_BURST-1.
- Not defined: the port is absent and behaviour is exactly as above.

Test Plan:
1. Reset release with req=16'h0001, en=16'hFFFF, out_ready=1 -> cycle 1: sel=0, grant=16'h0001, out_valid=1. After 4 fires, re-grant to channel 0 with no bubble, since it is the only requester.
2. req=16'h8421, en=16'hFFFF, out_ready=1, MAX_BURST=4 -> grants in order 0,5,10,15,0, each exactly 4 cycles. No gap cycles between grants.
3. Granted ch5 (req=16'h0021); drop req[5] mid-burst after 2 fires -> next edge grant=16'h0001, sel=0, beat_cnt restarts at 0.
4. req=16'h0300, en=16'h0100 -> only ch8 granted. Clearing en[8] mid-grant -> out_valid=0 next cycle, state IDLE, ch9 never granted.
5. out_ready=0 for 10 cycles during grant of ch3 -> grant=16'h0008 held and beat_cnt stays 0. Then 4 fires -> release. Assert rst mid-burst -> immediately sel=0, grant=0, out_valid=0.
6. (MUX16_ARB_LOCK_EN) lock=1, req=16'h0003, out_ready=1 -> ch0 holds for 20 fires. Drop lock -> release after the next fire, grant moves to ch1.
